// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Bundles the signals exchanged between the instruction fetch stage and its
// surroundings: hazard/redirect controls from downstream, the combinational
// instruction memory port, and the IF/ID pipeline register outputs.
//
//   stall        : hold PC and IF/ID this cycle (load-use hazard)
//   flush        : write a bubble into IF/ID at the next edge
//   redirect     : taken branch / resolved jump from downstream
//   redirect_pc  : target PC when redirect = 1
//   imem_addr    : address to instruction memory (equals pc)
//   imem_data    : instruction at imem_addr, same cycle
//   pc           : current fetch PC
//   if_id_instr  : registered instruction for decode
//   if_id_pc_inc : registered fetch PC + 1 of that instruction
//   if_id_valid  : 1 = real instruction, 0 = bubble
//   halted       : 1 while the fetch FSM is halted
//   fetch_count  : number of valid instructions written into IF/ID
//
// Modports: master = fetch stage side, slave = environment side.
// ---------------------------------------------------------------------------
interface fetch_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  modport master (
    input  stall, flush, redirect, redirect_pc, imem_data,
    output imem_addr, pc, if_id_instr, if_id_pc_inc, if_id_valid,
           halted, fetch_count
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, imem_data,
    input  imem_addr, pc, if_id_instr, if_id_pc_inc, if_id_valid,
           halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage of a simple 16-bit pipeline. Presents the PC to a
// combinational instruction memory, registers the returned instruction plus
// PC+1 into the IF/ID register, and halts fetching when it fetches an
// instruction whose opcode (instr[15:12]) equals HALT_OP.
//
// Ports:
//   clk    : single clock, rising-edge
//   reset  : asynchronous active-low reset
//   bus    : fetch_if.master (controls in, imem port, IF/ID outputs)
//
// Priority in RUN, per edge: redirect > stall > flush > normal fetch.
// In HALTED only redirect has any effect; every other edge inserts a bubble.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_inc_q, pc_inc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic [15:0] pc_plus1;
  logic        is_halt_op;

  assign pc_plus1   = pc_q + 16'd1;            // wraps modulo 2^16
  assign is_halt_op = (bus.imem_data[15:12] == HALT_OP);

  // Next-state and IF/ID update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_inc_d = pc_inc_q;
    valid_d  = valid_q;
    count_d  = count_q;

    unique case (state_q)
      RUN: begin
        if (bus.redirect) begin
          // Redirect wins over stall/flush and discards whatever is being
          // fetched this cycle, including a HALT opcode on the wrong path.
          pc_d     = bus.redirect_pc;
          instr_d  = 16'h0000;
          pc_inc_d = 16'h0000;
          valid_d  = 1'b0;
        end else if (bus.stall) begin
          // PC holds; a simultaneous flush still kills the IF/ID entry.
          // A HALT fetched under stall is simply re-fetched later.
          if (bus.flush) begin
            instr_d  = 16'h0000;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
          end
        end else if (bus.flush) begin
          pc_d     = pc_plus1;
          instr_d  = 16'h0000;
          pc_inc_d = 16'h0000;
          valid_d  = 1'b0;
        end else begin
          instr_d  = bus.imem_data;
          pc_inc_d = pc_plus1;
          valid_d  = 1'b1;
          count_d  = count_q + 16'd1;
          // The HALT instruction itself goes down the pipe; PC stays on it.
          if (is_halt_op) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus1;
          end
        end
      end

      HALTED: begin
        instr_d  = 16'h0000;
        pc_inc_d = 16'h0000;
        valid_d  = 1'b0;
        if (bus.redirect) begin
          // Halt was on a mispredicted path; resume at the target.
          state_d = RUN;
          pc_d    = bus.redirect_pc;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and IF/ID registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      pc_inc_q <= 16'h0000;
      valid_q  <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_inc_q <= pc_inc_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc_inc = pc_inc_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.halted       = (state_q == HALTED);
  assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_if bus ();

  fetch_stage #(
    .RESET_PC (16'h0000),
    .HALT_OP  (4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd,
                       input logic [15:0] rpc, input logic [15:0] data);
    bus.stall       = st;
    bus.flush       = fl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_data   = data;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr,
                          input logic [15:0] pinc, input logic vld);
    chk({tag, "_instr"}, bus.if_id_instr, instr);
    chk({tag, "_pcinc"}, bus.if_id_pc_inc, pinc);
    chk({tag, "_valid"}, {15'd0, bus.if_id_valid}, {15'd0, vld});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset state before any clock edge
    #3;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    chk("rst_cnt", bus.fetch_count, 16'h0000);
    chk("rst_halt", {15'd0, bus.halted}, 16'h0000);

    // Release between edges (edge at 5 happens under reset)
    #4;
    reset = 1'b1;

    // Two normal fetches
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
    edge1();
    chk_ifid("f1", 16'h1234, 16'h0001, 1'b1);
    chk("f1_pc", bus.pc, 16'h0001);
    chk("f1_cnt", bus.fetch_count, 16'h0001);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h2345);
    edge1();
    chk_ifid("f2", 16'h2345, 16'h0002, 1'b1);
    chk("f2_pc", bus.pc, 16'h0002);
    chk("f2_cnt", bus.fetch_count, 16'h0002);

    // Redirect to 4, fetch 0x1111 -> pc 5
    drive(1'b0, 1'b0, 1'b1, 16'h0004, 16'h9999);
    edge1();
    chk("rd4_pc", bus.pc, 16'h0004);
    chk("rd4_valid", {15'd0, bus.if_id_valid}, 16'h0000);
    chk("rd4_cnt", bus.fetch_count, 16'h0002);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1111);
    edge1();
    chk_ifid("f4", 16'h1111, 16'h0005, 1'b1);
    chk("f4_pc", bus.pc, 16'h0005);

    // Stall three edges at pc 5
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h2222);
    for (int i = 0; i < 3; i++) edge1();
    chk("stall_pc", bus.pc, 16'h0005);
    chk_ifid("stall", 16'h1111, 16'h0005, 1'b1);
    chk("stall_cnt", bus.fetch_count, 16'h0003);

    // Stall + flush
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h2222);
    edge1();
    chk_ifid("stfl", 16'h0000, 16'h0000, 1'b0);
    chk("stfl_pc", bus.pc, 16'h0005);
    chk("stfl_cnt", bus.fetch_count, 16'h0003);

    // Flush alone advances pc
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222);
    edge1();
    chk("fl_pc", bus.pc, 16'h0006);
    chk("fl_valid", {15'd0, bus.if_id_valid}, 16'h0000);
    chk("fl_cnt", bus.fetch_count, 16'h0003);

    // Redirect together with stall
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 16'h3333);
    edge1();
    chk("rdst_pc", bus.pc, 16'h0040);
    chk("rdst_valid", {15'd0, bus.if_id_valid}, 16'h0000);
    chk("rdst_cnt", bus.fetch_count, 16'h0003);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4444);
    edge1();
    chk_ifid("f40", 16'h4444, 16'h0041, 1'b1);
    chk("f40_pc", bus.pc, 16'h0041);
    chk("f40_cnt", bus.fetch_count, 16'h0004);

    // HALT at 0x10
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000);
    edge1();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF000);
    edge1();
    chk_ifid("halt", 16'hF000, 16'h0011, 1'b1);
    chk("halt_h", {15'd0, bus.halted}, 16'h0001);
    chk("halt_pc", bus.pc, 16'h0010);
    chk("halt_cnt", bus.fetch_count, 16'h0005);
    edge1();
    chk_ifid("hb1", 16'h0000, 16'h0000, 1'b0);
    chk("hb1_pc", bus.pc, 16'h0010);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'hF000);
    edge1();
    chk_ifid("hb2", 16'h0000, 16'h0000, 1'b0);
    chk("hb2_h", {15'd0, bus.halted}, 16'h0001);
    chk("hb2_pc", bus.pc, 16'h0010);
    chk("hb2_cnt", bus.fetch_count, 16'h0005);

    // Redirect out of HALTED
    drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'hF000);
    edge1();
    chk("hrd_h", {15'd0, bus.halted}, 16'h0000);
    chk("hrd_pc", bus.pc, 16'h0020);
    chk("hrd_valid", {15'd0, bus.if_id_valid}, 16'h0000);

    // Redirect in the same cycle a HALT is fetched
    drive(1'b0, 1'b0, 1'b1, 16'h0030, 16'hF000);
    edge1();
    chk("rdh_h", {15'd0, bus.halted}, 16'h0000);
    chk("rdh_pc", bus.pc, 16'h0030);
    chk("rdh_cnt", bus.fetch_count, 16'h0005);

    // Stall with a HALT fetch, then unstalled re-fetch
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'hF123);
    edge1();
    chk("sth_h", {15'd0, bus.halted}, 16'h0000);
    chk("sth_pc", bus.pc, 16'h0030);
    chk("sth_cnt", bus.fetch_count, 16'h0005);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF123);
    edge1();
    chk("sth2_h", {15'd0, bus.halted}, 16'h0001);
    chk_ifid("sth2", 16'hF123, 16'h0031, 1'b1);
    chk("sth2_pc", bus.pc, 16'h0030);
    chk("sth2_cnt", bus.fetch_count, 16'h0006);

    // Asynchronous reset pulse while halted
    reset = 1'b0;
    #1;
    chk("ar_h", {15'd0, bus.halted}, 16'h0000);
    chk("ar_pc", bus.pc, 16'h0000);
    chk_ifid("ar", 16'h0000, 16'h0000, 1'b0);
    chk("ar_cnt", bus.fetch_count, 16'h0000);
    #2;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555);
    edge1();
    chk_ifid("ar_f", 16'h5555, 16'h0001, 1'b1);
    chk("ar_f_pc", bus.pc, 16'h0001);
    chk("ar_f_cnt", bus.fetch_count, 16'h0001);

    // PC wrap at 0xFFFF
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    edge1();
    chk("wr_pc0", bus.pc, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h6666);
    edge1();
    chk("wr_pc", bus.pc, 16'h0000);
    chk_ifid("wr", 16'h6666, 16'h0000, 1'b1);
    chk("wr_cnt", bus.fetch_count, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
